// File: rtl/triangle_assembler_if.sv
// Triangle assembler bus bundle: pass control, index-buffer read, G-buffer read and triangle output.
interface triangle_assembler_if #(
    parameter int unsigned VERTEX_DATAWIDTH  = 12,
    parameter int unsigned MAX_NUM_VERTEXES  = 1024,
    parameter int unsigned MAX_NUM_TRIANGLES = 2048
);
    localparam int unsigned IDX_W = $clog2(MAX_NUM_VERTEXES);
    localparam int unsigned TRI_W = $clog2(MAX_NUM_TRIANGLES);
    localparam int unsigned VTX_W = 3 * VERTEX_DATAWIDTH;

    logic               start;
    logic [TRI_W:0]     num_triangles;
    logic               busy;
    logic               done;

    logic               idx_en;
    logic [TRI_W-1:0]   idx_addr;
    logic [3*IDX_W-1:0] idx_data;

    logic               gbuf_en;
    logic               gbuf_rw;
    logic               gbuf_ready;
    logic [IDX_W-1:0]   gbuf_addr0;
    logic [IDX_W-1:0]   gbuf_addr1;
    logic [IDX_W-1:0]   gbuf_addr2;
    logic [VTX_W-1:0]   gbuf_data0;
    logic [VTX_W-1:0]   gbuf_data1;
    logic [VTX_W-1:0]   gbuf_data2;
    logic               gbuf_dv;

    logic               tri_valid;
    logic               tri_ready;
    logic [VTX_W-1:0]   tri_v0;
    logic [VTX_W-1:0]   tri_v1;
    logic [VTX_W-1:0]   tri_v2;
    logic [TRI_W-1:0]   tri_id;
    logic               tri_last;

    modport master (
        input  start, num_triangles,
        output busy, done,
        output idx_en, idx_addr,
        input  idx_data,
        output gbuf_en, gbuf_rw, gbuf_addr0, gbuf_addr1, gbuf_addr2,
        input  gbuf_ready, gbuf_data0, gbuf_data1, gbuf_data2, gbuf_dv,
        output tri_valid, tri_v0, tri_v1, tri_v2, tri_id, tri_last,
        input  tri_ready
    );

    modport slave (
        output start, num_triangles,
        input  busy, done,
        input  idx_en, idx_addr,
        output idx_data,
        input  gbuf_en, gbuf_rw, gbuf_addr0, gbuf_addr1, gbuf_addr2,
        output gbuf_ready, gbuf_data0, gbuf_data1, gbuf_data2, gbuf_dv,
        input  tri_valid, tri_v0, tri_v1, tri_v2, tri_id, tri_last,
        output tri_ready
    );
endinterface

// File: rtl/triangle_assembler.sv
// Walks the index buffer, fetches three vertices per entry from the G-buffer and streams triangles.
// Optional macro TRIANGLE_ASSEMBLER_CULL_DEGENERATE_EN skips entries with repeated vertex indices.
module triangle_assembler #(
    parameter int unsigned VERTEX_DATAWIDTH  = 12,
    parameter int unsigned MAX_NUM_VERTEXES  = 1024,
    parameter int unsigned MAX_NUM_TRIANGLES = 2048
) (
    input  logic                 clk,
    input  logic                 rstn,
    triangle_assembler_if.master bus
);
    localparam int unsigned IDX_W = $clog2(MAX_NUM_VERTEXES);
    localparam int unsigned TRI_W = $clog2(MAX_NUM_TRIANGLES);
    localparam int unsigned CNT_W = TRI_W + 1;
    localparam int unsigned VTX_W = 3 * VERTEX_DATAWIDTH;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_IDX_REQ   = 3'd1;
    localparam logic [2:0] S_IDX_WAIT  = 3'd2;
    localparam logic [2:0] S_GBUF_REQ  = 3'd3;
    localparam logic [2:0] S_GBUF_WAIT = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [TRI_W-1:0] r_cnt;
    logic [TRI_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;
    logic [IDX_W-1:0] r_i0;
    logic [IDX_W-1:0] r_i1;
    logic [IDX_W-1:0] r_i2;
    logic [VTX_W-1:0] r_v0;
    logic [VTX_W-1:0] r_v1;
    logic [VTX_W-1:0] r_v2;
    logic             r_busy;
    logic             r_done;
    logic             r_idx_en;
    logic             r_tri_valid;
    logic             r_tri_last;

    logic [IDX_W-1:0] w_i0;
    logic [IDX_W-1:0] w_i1;
    logic [IDX_W-1:0] w_i2;
    logic             w_is_last;
    logic             w_degenerate;

    assign w_i0      = bus.idx_data[IDX_W-1:0];
    assign w_i1      = bus.idx_data[2*IDX_W-1:IDX_W];
    assign w_i2      = bus.idx_data[3*IDX_W-1:2*IDX_W];
    assign w_is_last = ({1'b0, r_cnt} == (r_count - CNT_W'(1)));

`ifdef TRIANGLE_ASSEMBLER_CULL_DEGENERATE_EN
    assign w_degenerate = (w_i0 == w_i1) || (w_i1 == w_i2) || (w_i0 == w_i2);
`else
    assign w_degenerate = 1'b0;
`endif

    // Next-state and counter update
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_triangles == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_count = bus.num_triangles;
                        w_next_cnt   = '0;
                        w_next_state = S_IDX_REQ;
                    end
                end
            end
            S_IDX_REQ:  w_next_state = S_IDX_WAIT;
            S_IDX_WAIT: begin
                if (w_degenerate) begin
                    if (w_is_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_cnt   = r_cnt + TRI_W'(1);
                        w_next_state = S_IDX_REQ;
                    end
                end else begin
                    w_next_state = S_GBUF_REQ;
                end
            end
            S_GBUF_REQ: begin
                if (bus.gbuf_ready) w_next_state = S_GBUF_WAIT;
            end
            S_GBUF_WAIT: begin
                if (bus.gbuf_dv) w_next_state = S_OUT;
            end
            S_OUT: begin
                if (bus.tri_ready) begin
                    if (w_is_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_cnt   = r_cnt + TRI_W'(1);
                        w_next_state = S_IDX_REQ;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, captured data and registered status/strobe outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_count     <= '0;
            r_i0        <= '0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_v0        <= '0;
            r_v1        <= '0;
            r_v2        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_idx_en    <= 1'b0;
            r_tri_valid <= 1'b0;
            r_tri_last  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_count     <= w_next_count;
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
            r_idx_en    <= (w_next_state == S_IDX_REQ);
            r_tri_valid <= (w_next_state == S_OUT);
            r_tri_last  <= (w_next_state == S_OUT) && w_is_last;
            if (r_state == S_IDX_WAIT) begin
                r_i0 <= w_i0;
                r_i1 <= w_i1;
                r_i2 <= w_i2;
            end
            if ((r_state == S_GBUF_WAIT) && bus.gbuf_dv) begin
                r_v0 <= bus.gbuf_data0;
                r_v1 <= bus.gbuf_data1;
                r_v2 <= bus.gbuf_data2;
            end
        end
    end

    // The G-buffer strobe must coincide with its ready, so it is the one combinational output
    assign bus.gbuf_en    = (r_state == S_GBUF_REQ) && bus.gbuf_ready;
    assign bus.gbuf_rw    = 1'b0;
    assign bus.gbuf_addr0 = r_i0;
    assign bus.gbuf_addr1 = r_i1;
    assign bus.gbuf_addr2 = r_i2;

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.idx_en    = r_idx_en;
    assign bus.idx_addr  = r_cnt;
    assign bus.tri_valid = r_tri_valid;
    assign bus.tri_v0    = r_v0;
    assign bus.tri_v1    = r_v1;
    assign bus.tri_v2    = r_v2;
    assign bus.tri_id    = r_cnt;
    assign bus.tri_last  = r_tri_last;
endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler with index-buffer and 4-cycle G-buffer models.
module tb_triangle_assembler;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned TRI_W = 11;
    localparam int unsigned VTX_W = 36;

    logic clk;
    logic rstn;
    logic spur_dv;
    logic [3:0] m_sh;
    logic [IDX_W-1:0] m_a0, m_a1, m_a2;
    logic [3*IDX_W-1:0] idx_mem [0:7];
    int gbuf_en_total;

    int checks;
    int failures;

    int hs_n, done_n, done_cyc, stall_bad, stall_idx_en;
    int hs_id [0:7];
    int hs_last [0:7];
    logic [VTX_W-1:0] hs_v0 [0:7];

    typedef struct packed {
        logic [IDX_W-1:0] i0;
        logic [IDX_W-1:0] i1;
        logic [IDX_W-1:0] i2;
        logic [VTX_W-1:0] v0;
        logic [VTX_W-1:0] v1;
        logic [VTX_W-1:0] v2;
    } vec_t;

    triangle_assembler_if bus ();

    triangle_assembler u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index buffer: one-cycle read latency
    always @(posedge clk) begin
        if (bus.idx_en) bus.idx_data <= idx_mem[bus.idx_addr[2:0]];
    end

    // G-buffer: data valid 4 cycles after the request, addresses sampled late
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_sh <= '0;
            m_a0 <= '0;
            m_a1 <= '0;
            m_a2 <= '0;
        end else begin
            m_sh <= {m_sh[2:0], bus.gbuf_en};
            if (m_sh[2]) begin
                m_a0 <= bus.gbuf_addr0;
                m_a1 <= bus.gbuf_addr1;
                m_a2 <= bus.gbuf_addr2;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.gbuf_en) gbuf_en_total <= gbuf_en_total + 1;
    end

    assign bus.gbuf_dv    = m_sh[3] | spur_dv;
    assign bus.gbuf_data0 = VTX_W'(m_a0) * 36'h111;
    assign bus.gbuf_data1 = VTX_W'(m_a1) * 36'h111;
    assign bus.gbuf_data2 = VTX_W'(m_a2) * 36'h111;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one pass with optional back-pressure on one triangle id, recording handshakes
    task automatic run_pass(input int n, input int stall_id, input int stall_len, input int max_cyc);
        int stall_cnt;
        logic [VTX_W-1:0] held_v0;
        logic [TRI_W-1:0] held_id;
        logic held_last;
        bit seen_done;
        hs_n = 0; done_n = 0; done_cyc = -1; stall_bad = 0; stall_idx_en = 0;
        stall_cnt = 0; seen_done = 0; held_v0 = '0; held_id = '0; held_last = 1'b0;
        for (int j = 0; j < 8; j++) begin
            hs_id[j] = -1; hs_last[j] = -1; hs_v0[j] = '1;
        end
        bus.num_triangles = (TRI_W+1)'(n);
        bus.start = 1'b1;
        for (int c = 1; c <= max_cyc && !seen_done; c++) begin
            step();
            bus.start = 1'b0;
            if (bus.done) begin
                done_n++; done_cyc = c; seen_done = 1;
            end
            if (bus.tri_valid) begin
                if (int'(bus.tri_id) == stall_id && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        held_v0 = bus.tri_v0; held_id = bus.tri_id; held_last = bus.tri_last;
                    end else if (bus.tri_v0 !== held_v0 || bus.tri_id !== held_id ||
                                 bus.tri_last !== held_last) begin
                        stall_bad++;
                    end
                    if (bus.idx_en) stall_idx_en++;
                    stall_cnt++;
                    bus.tri_ready = 1'b0;
                end else begin
                    bus.tri_ready = 1'b1;
                    if (hs_n < 8) begin
                        hs_id[hs_n] = int'(bus.tri_id);
                        hs_last[hs_n] = int'(bus.tri_last);
                        hs_v0[hs_n] = bus.tri_v0;
                    end
                    hs_n++;
                end
            end else begin
                bus.tri_ready = 1'b1;
            end
        end
        bus.tri_ready = 1'b1;
        chk("pass_done_seen", 64'(seen_done), 1);
        step();
        chk("pass_done_pulse", 64'(bus.done), 0);
        chk("pass_busy_fall", 64'(bus.busy), 0);
    endtask

    vec_t vecs [0:2];
    int exp_n, exp_done;
    int exp_id [0:2];
    int exp_last [0:2];
    logic [VTX_W-1:0] exp_v0 [0:2];
    logic [IDX_W-1:0] a0_hold, a1_hold, a2_hold;
    int gb0;

    initial begin
        checks = 0; failures = 0; gbuf_en_total = 0;
        vecs[0] = '{i0: 10'd1, i1: 10'd3,   i2: 10'd5,
                    v0: 36'h111, v1: 36'h333,   v2: 36'h555};
        vecs[1] = '{i0: 10'd0, i1: 10'h200, i2: 10'h3FF,
                    v0: 36'h0,   v1: 36'h22200, v2: 36'h442EF};
        vecs[2] = '{i0: 10'd7, i1: 10'h10,  i2: 10'd2,
                    v0: 36'h777, v1: 36'h1110,  v2: 36'h222};
        for (int j = 0; j < 8; j++) idx_mem[j] = '0;

        rstn = 1'b0; spur_dv = 1'b0;
        bus.start = 1'b0; bus.num_triangles = '0;
        bus.gbuf_ready = 1'b1; bus.tri_ready = 1'b1;
        repeat (3) step();
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_idx_en", 64'(bus.idx_en), 0);
        chk("rst_gbuf_en", 64'(bus.gbuf_en), 0);
        chk("rst_gbuf_rw", 64'(bus.gbuf_rw), 0);
        chk("rst_tri_valid", 64'(bus.tri_valid), 0);
        chk("rst_tri_last", 64'(bus.tri_last), 0);
        chk("rst_tri_id", 64'(bus.tri_id), 0);
        chk("rst_gbuf_addr0", 64'(bus.gbuf_addr0), 0);
        chk("rst_tri_v0", 64'(bus.tri_v0), 0);
        rstn = 1'b1;
        step();

        // Zero-triangle pass
        bus.num_triangles = '0; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk("zero_done_c1", 64'(bus.done), 1);
        chk("zero_idx_en_c1", 64'(bus.idx_en), 0);
        chk("zero_gbuf_en_c1", 64'(bus.gbuf_en), 0);
        step();
        chk("zero_done_c2", 64'(bus.done), 0);
        chk("zero_busy_c2", 64'(bus.busy), 0);
        chk("zero_idx_en_c2", 64'(bus.idx_en), 0);

        // Single-triangle vectors with cycle-exact latency
        for (int k = 0; k < 3; k++) begin
            idx_mem[0] = {vecs[k].i2, vecs[k].i1, vecs[k].i0};
            bus.num_triangles = 12'd1; bus.start = 1'b1;
            step(); bus.start = 1'b0;
            chk("vec_idx_en_c1", 64'(bus.idx_en), 1);
            chk("vec_idx_addr_c1", 64'(bus.idx_addr), 0);
            step(); step();
            chk("vec_gbuf_en_c3", 64'(bus.gbuf_en), 1);
            chk("vec_gbuf_addr0", 64'(bus.gbuf_addr0), 64'(vecs[k].i0));
            chk("vec_gbuf_addr1", 64'(bus.gbuf_addr1), 64'(vecs[k].i1));
            chk("vec_gbuf_addr2", 64'(bus.gbuf_addr2), 64'(vecs[k].i2));
            repeat (4) step();
            chk("vec_tri_valid_c7", 64'(bus.tri_valid), 0);
            step();
            chk("vec_tri_valid_c8", 64'(bus.tri_valid), 1);
            chk("vec_tri_v0", 64'(bus.tri_v0), 64'(vecs[k].v0));
            chk("vec_tri_v1", 64'(bus.tri_v1), 64'(vecs[k].v1));
            chk("vec_tri_v2", 64'(bus.tri_v2), 64'(vecs[k].v2));
            chk("vec_tri_id", 64'(bus.tri_id), 0);
            chk("vec_tri_last", 64'(bus.tri_last), 1);
            step();
            chk("vec_done_c9", 64'(bus.done), 1);
            chk("vec_tri_valid_c9", 64'(bus.tri_valid), 0);
            step();
            chk("vec_busy_c10", 64'(bus.busy), 0);
        end

        // Back-pressure: triangle 1 stalled 5 cycles
        idx_mem[0] = {10'd3, 10'd2, 10'd1};
        idx_mem[1] = {10'h22, 10'h21, 10'h20};
        idx_mem[2] = {10'h32, 10'h31, 10'h30};
        run_pass(3, 1, 5, 200);
        chk("bp_hs_n", 64'(hs_n), 3);
        chk("bp_id0", 64'(hs_id[0]), 0);
        chk("bp_id1", 64'(hs_id[1]), 1);
        chk("bp_id2", 64'(hs_id[2]), 2);
        chk("bp_last0", 64'(hs_last[0]), 0);
        chk("bp_last1", 64'(hs_last[1]), 0);
        chk("bp_last2", 64'(hs_last[2]), 1);
        chk("bp_v0_0", 64'(hs_v0[0]), 64'h111);
        chk("bp_v0_1", 64'(hs_v0[1]), 64'h2220);
        chk("bp_v0_2", 64'(hs_v0[2]), 64'h3330);
        chk("bp_stall_stable", 64'(stall_bad), 0);
        chk("bp_stall_idx_en", 64'(stall_idx_en), 0);
        chk("bp_done_cycle", 64'(done_cyc), 30);
        chk("bp_done_count", 64'(done_n), 1);

        // G-buffer stall with spurious data-valid and ignored start
        idx_mem[0] = {10'd9, 10'd6, 10'd4};
        gb0 = gbuf_en_total;
        bus.gbuf_ready = 1'b0;
        bus.num_triangles = 12'd1; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk("gs_idx_en_c1", 64'(bus.idx_en), 1);
        step(); spur_dv = 1'b1;
        step(); spur_dv = 1'b0;
        chk("gs_gbuf_en_c3", 64'(bus.gbuf_en), 0);
        a0_hold = bus.gbuf_addr0; a1_hold = bus.gbuf_addr1; a2_hold = bus.gbuf_addr2;
        chk("gs_addr0", 64'(a0_hold), 4);
        chk("gs_addr1", 64'(a1_hold), 6);
        chk("gs_addr2", 64'(a2_hold), 9);
        step();
        bus.num_triangles = 12'd3; bus.start = 1'b1;
        chk("gs_gbuf_en_c4", 64'(bus.gbuf_en), 0);
        step(); bus.start = 1'b0;
        chk("gs_gbuf_en_c5", 64'(bus.gbuf_en), 0);
        chk("gs_addr_stable", 64'({bus.gbuf_addr2, bus.gbuf_addr1, bus.gbuf_addr0}),
            64'({a2_hold, a1_hold, a0_hold}));
        step(); bus.gbuf_ready = 1'b1; #1;
        chk("gs_gbuf_en_c6", 64'(bus.gbuf_en), 1);
        repeat (4) step();
        chk("gs_tri_valid_c10", 64'(bus.tri_valid), 0);
        step();
        chk("gs_tri_valid_c11", 64'(bus.tri_valid), 1);
        chk("gs_tri_v0", 64'(bus.tri_v0), 64'h444);
        chk("gs_tri_v1", 64'(bus.tri_v1), 64'h666);
        chk("gs_tri_v2", 64'(bus.tri_v2), 64'h999);
        chk("gs_tri_last", 64'(bus.tri_last), 1);
        step();
        chk("gs_done_c12", 64'(bus.done), 1);
        step();
        chk("gs_busy_c13", 64'(bus.busy), 0);
        chk("gs_gbuf_en_count", 64'(gbuf_en_total - gb0), 1);

        // Abort in GBUF_WAIT, then a clean two-triangle pass
        idx_mem[0] = {10'd6, 10'd5, 10'd2};
        idx_mem[1] = {10'd13, 10'd12, 10'd11};
        bus.num_triangles = 12'd2; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        repeat (4) step();
        chk("ab_busy_before", 64'(bus.busy), 1);
        rstn = 1'b0; #1;
        chk("ab_busy", 64'(bus.busy), 0);
        chk("ab_tri_valid", 64'(bus.tri_valid), 0);
        chk("ab_done", 64'(bus.done), 0);
        chk("ab_idx_en", 64'(bus.idx_en), 0);
        chk("ab_gbuf_en", 64'(bus.gbuf_en), 0);
        chk("ab_tri_v0", 64'(bus.tri_v0), 0);
        step(); step();
        rstn = 1'b1;
        repeat (6) step();
        chk("ab_no_partial", 64'({bus.tri_valid, bus.busy, bus.done}), 0);
        run_pass(2, -1, 0, 100);
        chk("ab_hs_n", 64'(hs_n), 2);
        chk("ab_id0", 64'(hs_id[0]), 0);
        chk("ab_id1", 64'(hs_id[1]), 1);
        chk("ab_last0", 64'(hs_last[0]), 0);
        chk("ab_last1", 64'(hs_last[1]), 1);
        chk("ab_v0_0", 64'(hs_v0[0]), 64'h222);
        chk("ab_v0_1", 64'(hs_v0[1]), 64'hBBB);
        chk("ab_done_cycle", 64'(done_cyc), 17);

        // Degenerate entry in the middle of a pass
        idx_mem[0] = {10'd3, 10'd2, 10'd1};
        idx_mem[1] = {10'd7, 10'd4, 10'd4};
        idx_mem[2] = {10'd10, 10'd9, 10'd8};
`ifdef TRIANGLE_ASSEMBLER_CULL_DEGENERATE_EN
        exp_n = 2; exp_done = 19;
        exp_id[0] = 0; exp_last[0] = 0; exp_v0[0] = 36'h111;
        exp_id[1] = 2; exp_last[1] = 1; exp_v0[1] = 36'h888;
        exp_id[2] = -1; exp_last[2] = -1; exp_v0[2] = '1;
`else
        exp_n = 3; exp_done = 25;
        exp_id[0] = 0; exp_last[0] = 0; exp_v0[0] = 36'h111;
        exp_id[1] = 1; exp_last[1] = 0; exp_v0[1] = 36'h444;
        exp_id[2] = 2; exp_last[2] = 1; exp_v0[2] = 36'h888;
`endif
        run_pass(3, -1, 0, 200);
        chk("cull_hs_n", 64'(hs_n), 64'(exp_n));
        for (int j = 0; j < 3; j++) begin
            chk("cull_id", 64'(hs_id[j]), 64'(exp_id[j]));
            chk("cull_last", 64'(hs_last[j]), 64'(exp_last[j]));
            chk("cull_v0", 64'(hs_v0[j]), 64'(exp_v0[j]));
        end
        chk("cull_done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("cull_done_count", 64'(done_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/triangle_assembler.md
# triangle_assembler

Triangle assembler sits directly downstream of the G-buffer vertex store and feeds the rasterizer. On `start` it walks an index buffer of `num_triangles` entries, each holding three vertex indices. For every entry it issues one three-port read to the G-buffer, waits for its data-valid, and presents the assembled triangle (three transformed vertices plus triangle ID) on a valid/ready output.

## Interface
Parameters:
- `VERTEX_DATAWIDTH`, 12, bits per x/y/z component; a vertex is `3*VERTEX_DATAWIDTH` bits.
- `MAX_NUM_VERTEXES`, 1024, G-buffer depth; `IDX_W = $clog2(MAX_NUM_VERTEXES)`.
- `MAX_NUM_TRIANGLES`, 2048, index-buffer depth; `TRI_W = $clog2(MAX_NUM_TRIANGLES)`.

Ports:
- `clk` in 1 — single clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `start` in 1 — begin a pass; honoured in IDLE only.
- `num_triangles` in TRI_W+1 — triangle count, latched on accepted `start`.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at end of pass.
- `idx_en` out 1 — index-buffer read strobe.
- `idx_addr` out TRI_W — index-buffer address.
- `idx_data` in 3*IDX_W — `{i2,i1,i0}`, i0 in LSBs; valid the cycle after `idx_en`.
- `gbuf_en` out 1 — G-buffer request strobe.
- `gbuf_rw` out 1 — tied 0 (read only).
- `gbuf_ready` in 1 — G-buffer idle.
- `gbuf_addr0/1/2` out IDX_W each — vertex indices i0/i1/i2.
- `gbuf_data0/1/2` in 3*VERTEX_DATAWIDTH each — vertex data.
- `gbuf_dv` in 1 — G-buffer data valid.
- `tri_valid` out 1 — output triangle valid.
- `tri_ready` in 1 — rasterizer accepts.
- `tri_v0/v1/v2` out 3*VERTEX_DATAWIDTH each — vertex data.
- `tri_id` out TRI_W — index-buffer position of this triangle.
- `tri_last` out 1 — this triangle is the final one of the pass.

## Operation
- Reset state IDLE; all outputs 0; internal counter and captured data cleared.
- States: IDLE, IDX_REQ, IDX_WAIT, GBUF_REQ, GBUF_WAIT, OUT, DONE.
- **IDLE**
  - `start` with `num_triangles`=0 → DONE.
  - `start` with `num_triangles`>0 → latch count, counter=0 → IDX_REQ.
- **IDX_REQ**: `idx_en`=1, `idx_addr`=counter → IDX_WAIT.
- **IDX_WAIT**: capture `idx_data` into the three index registers → GBUF_REQ.
- **GBUF_REQ**
  - `gbuf_en`=1 only in the cycle where `gbuf_ready`=1, then → GBUF_WAIT.
  - Otherwise hold in GBUF_REQ.
- **GBUF_WAIT**: on `gbuf_dv`, capture `gbuf_data0..2` into `tri_v0..2` → OUT.
- **G-buffer address hold**: `gbuf_addr0..2` driven from the index registers and stable from GBUF_REQ through GBUF_WAIT. The G-buffer samples them over successive cycles.
- **OUT**
  - `tri_valid`=1; `tri_v*`, `tri_id`=counter and `tri_last`=(counter==count-1) held stable until `tri_ready`.
  - On handshake: if last → DONE; else counter+1 → IDX_REQ.
- **DONE**: `done`=1 for one cycle → IDLE.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `gbuf_dv` outside GBUF_WAIT is ignored.
- **Index range**: indices are used unchecked; range is by construction `< MAX_NUM_VERTEXES`.
- **Count range**: `num_triangles` > MAX_NUM_TRIANGLES is undefined; the bench must not drive it.
- **Reset mid-operation**: any state → IDLE immediately; `tri_valid`, `busy`, `done` and strobes drop asynchronously; no partial triangle is emitted afterwards.

## Timing
- `idx_data` latency: 1 cycle after `idx_en`.
- G-buffer latency: `gbuf_dv` 4 cycles after the `gbuf_en` cycle. The block tolerates any latency ≥1 by waiting.
- With `start` sampled in cycle 0 and `gbuf_ready`/`tri_ready` held high:
  - `idx_en` in cycle 1.
  - `gbuf_en` in cycle 3.
  - `gbuf_dv` in cycle 7.
  - `tri_valid` in cycle 8.
- Steady-state throughput: one triangle per 8 cycles.
- Each extra cycle of `tri_ready`=0 or `gbuf_ready`=0 adds one cycle.
- `done` is asserted the cycle after the last handshake; `busy` falls the cycle after `done`.
- Accepting `start` with `num_triangles`=0 gives `done` in cycle 1.

## Configuration
- `TRIANGLE_ASSEMBLER_CULL_DEGENERATE_EN`
  - **Defined**: in IDX_WAIT, if i0==i1, i1==i2 or i0==i2, the triangle is skipped: no G-buffer request, no output. The block increments the counter → IDX_REQ, or → DONE if it was the last. `tri_id` of emitted triangles keeps index-buffer position, so gaps appear. `tri_last` is asserted only if the final entry is non-degenerate; if the final entry is culled, `done` alone marks the end.
  - **Undefined**: every entry is emitted unchanged.

## Test plan
- **Reset**: `rstn` low → all outputs 0, IDLE. Release, `start` with `num_triangles`=0 → `done` in cycle 1, no `idx_en`/`gbuf_en`.
- **Single triangle**: indices {5,3,1}, G-buffer model returns data = index·0x111 after 4 cycles → `tri_valid` in cycle 8. Expect `gbuf_addr0/1/2`=1/3/5, `tri_v0`=0x111, `tri_v1`=0x333, `tri_v2`=0x555, `tri_id`=0, `tri_last`=1, then `done`.
- **Back-pressure**: 3 triangles, `tri_ready` low 5 cycles on triangle 1 → outputs held stable, no new `idx_en` until handshake. `tri_id` sequence 0,1,2; `tri_last` only on 2.
- **G-buffer stall**: `gbuf_ready` low 3 cycles in GBUF_REQ → `gbuf_en` held off, addresses stable, a single `gbuf_en` pulse when ready. A spurious `gbuf_dv` in IDX_WAIT is ignored.
- **Abort**: `rstn` pulsed low in GBUF_WAIT → outputs 0 immediately. Following `start` with 2 triangles completes normally.
- **Culling (macro defined)**: entries {1,2,3},{4,4,7},{8,9,10} → two triangles with `tri_id` 0 and 2, one `done`. Macro undefined → three triangles emitted.
